inv_round_transform: RTL and testbench
======================================

INV_ROUND_TRANSFORM -- requirements
Module: inv_round_transform

Interface
REQ-001 Parameter LAST_ROUND, default 0: 1 = final decryption round, InvMixColumns omitted; 0 = full inverse round.
REQ-002 Port round_clk, input, 1: single clock; all state on rising edge.
REQ-003 Port round_rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port round_en, input, 1: pipeline advance enable; low = entire pipeline holds.
REQ-005 Port round_valid_in, input, 1: round_datain/round_keyin carry a valid block this cycle.
REQ-006 Port round_datain, input, 128: cipher state; byte 0 = bits[127:120], column-major (column c = bits[127-32c -: 32], row r = byte r of the column).
REQ-007 Port round_keyin, input, 128: round key for this block, same byte order.
REQ-008 Port round_dataout, output, 128: result state.
REQ-009 Port round_dataout_valid, output, 1: round_dataout holds a valid result.

Function
REQ-010 Transform order: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (InvMixColumns skipped when LAST_ROUND=1).
REQ-011 InvShiftRows: out[r][c] = in[r][(c-r) mod 4], r,c in 0..3.
REQ-012 InvSubBytes: each byte replaced by the FIPS-197 inverse S-box value.
REQ-013 AddRoundKey: bitwise 128-bit XOR with the key sampled together with the same block.
REQ-014 InvMixColumns: per column, matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11B.
REQ-015 Stage 1 register: InvSubBytes(InvShiftRows(round_datain)), key copy, valid bit; loaded when round_en=1.
REQ-016 Stage 2 register: stage-1 state XOR stage-1 key, valid bit; loaded when round_en=1.
REQ-017 Stage 3 register (output): InvMixColumns(stage 2) or stage 2 unchanged per LAST_ROUND, valid bit; loaded when round_en=1.
REQ-018 Latency: result of a block accepted at edge N appears at outputs after edge N+2 counted in round_en-high edges (3 enabled edges total), independent of LAST_ROUND.
REQ-019 Throughput: one block per enabled cycle; back-to-back valid inputs produce back-to-back valid outputs in order.
REQ-020 Valid bits propagate with data; round_valid_in=0 inserts a bubble and round_dataout_valid=0 exactly three enabled edges later.
REQ-021 Data registers load even for invalid beats; only valid bits define meaning; an all-zero result with valid=1 is legal and flagged valid.
REQ-022 round_en=0: all data and valid registers hold; round_dataout_valid remains at its current value (no pulse-stretch suppression, no loss).
REQ-023 Key used for a block is the round_keyin present at that block's input sampling edge; later round_keyin changes do not affect it.

Reset
REQ-024 round_rst_n low asynchronously clears all stage data to 128'h0 and all valid bits to 0; round_dataout=0, round_dataout_valid=0 immediately.
REQ-025 Reset mid-operation discards all in-flight blocks; first valid output after release requires a new input plus full latency.
REQ-026 Reset release is sampled at round_clk; no register updates on the release edge unless round_en=1 then.

Verification
REQ-027 LAST_ROUND=1, round_datain=d4bf5d30e0b452aeb84111f11e2798e5, round_keyin=0, valid, round_en=1 -> after 3 edges round_dataout=193de3bea0f4e22b9ac68d2ae9f84808, valid=1 for one cycle.
REQ-028 LAST_ROUND=0, round_datain=d4bf5d30e0b452aeb84111f11e2798e5, round_keyin=1d5b625b403ffbb1d23e5e50c1fe6e44 -> round_dataout=d4bf5d30e0b452aeb84111f11e2798e5, valid=1, after 3 edges.
REQ-029 Stream of 8 valid blocks with alternating keys, then a bubble pattern 1,0,1 -> outputs in order, each matching a software inverse-round model, valid pattern delayed 3 cycles exactly.
REQ-030 Drop round_en for 5 cycles with 3 blocks in flight -> outputs and valid frozen; on re-enable blocks emerge in order, none duplicated or lost.
REQ-031 Assert round_rst_n=0 asynchronously between edges with 2 blocks in flight -> round_dataout=0, valid=0 immediately; no stale block emerges after release.
REQ-032 Change round_keyin one cycle after a valid input -> that block's result uses the key sampled with it.

Source files
------------

// File: rtl/inv_round_transform.sv
// Inverse AES round as a 3-stage pipeline: InvShiftRows+InvSubBytes | AddRoundKey | InvMixColumns.
// Valid bits ride a shift register beside the data; round_en stalls every stage together.

module inv_sbox_lane (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:255][7:0] INV_SBOX = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign y = INV_SBOX[a];
endmodule

module inv_mix_col (
   input  logic [31:0] col,
   output logic [31:0] mixed
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a [4];
   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];

   // 9/b/d/e multiples built from shared x2/x4/x8 doublings
   always_comb begin
      mixed = '0;
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[31-8*r -: 8];
         m9[r] = xt(xt(xt(a[r]))) ^ a[r];
         mb[r] = xt(xt(xt(a[r]))) ^ xt(a[r]) ^ a[r];
         md[r] = xt(xt(xt(a[r]))) ^ xt(xt(a[r])) ^ a[r];
         me[r] = xt(xt(xt(a[r]))) ^ xt(xt(a[r])) ^ xt(a[r]);
      end
      for (int r = 0; r < 4; r++)
         mixed[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
   end
endmodule

module inv_round_transform #(
   parameter int unsigned LAST_ROUND = 0
) (
   input  logic         round_clk,
   input  logic         round_rst_n,
   input  logic         round_en,
   input  logic         round_valid_in,
   input  logic [127:0] round_datain,
   input  logic [127:0] round_keyin,
   output logic [127:0] round_dataout,
   output logic         round_dataout_valid
);
   localparam int STAGES = 3;

   logic [STAGES:1] vld_pipe;
   logic [127:0]    shifted, subbed, mixed;
   logic [127:0]    s1_data, s1_key, s2_data, s3_data;

   // byte 4c+r sits at bits [127-8(4c+r) -: 8]; row r rotates right by r columns
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign shifted[127-8*(4*c+r) -: 8] = round_datain[127-8*(4*((c-r+4)%4)+r) -: 8];
         inv_sbox_lane u_sbox (
            .a (shifted[127-8*(4*c+r) -: 8]),
            .y (subbed[127-8*(4*c+r) -: 8])
         );
      end
   end

   if (LAST_ROUND != 0) begin : g_last
      assign mixed = s2_data;
   end else begin : g_mix
      for (genvar c = 0; c < 4; c++) begin : g_mcol
         inv_mix_col u_mix (
            .col   (s2_data[127-32*c -: 32]),
            .mixed (mixed[127-32*c -: 32])
         );
      end
   end

   always_ff @(posedge round_clk or negedge round_rst_n) begin
      if (!round_rst_n) begin
         vld_pipe <= '0;
         s1_data  <= '0;
         s1_key   <= '0;
         s2_data  <= '0;
         s3_data  <= '0;
      end else if (round_en) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], round_valid_in};
         s1_data  <= subbed;
         s1_key   <= round_keyin;
         s2_data  <= s1_data ^ s1_key;
         s3_data  <= mixed;
      end
   end

   assign round_dataout       = s3_data;
   assign round_dataout_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_inv_round_transform.sv
// Drives a full-round and a last-round instance side by side against an
// independently derived inverse-round model (S-box built from GF inverse + affine).

module tb_inv_round_transform;
   localparam logic [127:0] D   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] K28 = 128'h1d5b625b403ffbb1d23e5e50c1fe6e44;
   localparam logic [127:0] R27 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] KA  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] KB  = 128'hfedcba98765432100123456789abcdef;

   logic         round_clk = 1'b0;
   logic         round_rst_n = 1'b1;
   logic         round_en = 1'b0;
   logic         round_valid_in = 1'b0;
   logic [127:0] round_datain = '0;
   logic [127:0] round_keyin = '0;
   logic [127:0] out0, out1;
   logic         vld0, vld1;

   always #5 round_clk = ~round_clk;

   inv_round_transform #(.LAST_ROUND(0)) dut0 (
      .round_clk (round_clk), .round_rst_n (round_rst_n), .round_en (round_en),
      .round_valid_in (round_valid_in), .round_datain (round_datain), .round_keyin (round_keyin),
      .round_dataout (out0), .round_dataout_valid (vld0)
   );
   inv_round_transform #(.LAST_ROUND(1)) dut1 (
      .round_clk (round_clk), .round_rst_n (round_rst_n), .round_en (round_en),
      .round_valid_in (round_valid_in), .round_datain (round_datain), .round_keyin (round_keyin),
      .round_dataout (out1), .round_dataout_valid (vld1)
   );

   int           n_chk = 0;
   int           n_fail = 0;
   logic [7:0]   isbox [256];
   logic [127:0] hist_d [$];
   logic [127:0] hist_k [$];
   logic [127:0] exp0 = '0;
   logic [127:0] exp1 = '0;

   typedef struct {
      logic         v;
      logic         en;
      logic [127:0] d;
      logic [127:0] k;
      logic         ev;
   } vec_t;
   vec_t tbl [24];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      if (x == 8'h00) return 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
      return 8'h00;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input bit last);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            t[4*c+rr] = isbox[s[4*((c-rr+4)%4)+rr]] ^ k[127-8*(4*c+rr) -: 8];
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            m[4*c+rr] = gmul(8'h0e, t[4*c+rr])         ^ gmul(8'h0b, t[4*c+(rr+1)%4]) ^
                        gmul(8'h0d, t[4*c+(rr+2)%4])   ^ gmul(8'h09, t[4*c+(rr+3)%4]);
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? t[i] : m[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // One clock: apply inputs, then check both instances just after the edge.
   task automatic tick(input string tag, input logic v, input logic en,
                       input logic [127:0] d, input logic [127:0] k, input logic ev);
      int n;
      round_valid_in = v;
      round_en       = en;
      round_datain   = d;
      round_keyin    = k;
      @(posedge round_clk);
      #1;
      if (en) begin
         hist_d.push_back(d);
         hist_k.push_back(k);
         n = hist_d.size();
         if (n >= 3) begin
            exp0 = model(hist_d[n-3], hist_k[n-3], 1'b0);
            exp1 = model(hist_d[n-3], hist_k[n-3], 1'b1);
         end else begin
            exp0 = '0;
            exp1 = '0;
         end
      end
      chk({tag, " data0"}, out0, exp0);
      chk({tag, " data1"}, out1, exp1);
      chk({tag, " valid0"}, {127'd0, vld0}, {127'd0, ev});
      chk({tag, " valid1"}, {127'd0, vld1}, {127'd0, ev});
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " data0"}, out0, 128'h0);
      chk({tag, " data1"}, out1, 128'h0);
      chk({tag, " valid0"}, {127'd0, vld0}, 128'h0);
      chk({tag, " valid1"}, {127'd0, vld1}, 128'h0);
   endtask

   initial begin
      logic [23:0] vp, ep, evp;
      for (int x = 0; x < 256; x++) isbox[affine(ginv(8'(x)))] = 8'(x);

      vp  = 24'h1FE5FF;
      ep  = 24'hE0FFFF;
      evp = 24'h7F97FC;
      for (int i = 0; i < 24; i++) begin
         tbl[i].v  = vp[i];
         tbl[i].en = ep[i];
         tbl[i].d  = 128'h00112233445566778899aabbccddeeff ^ {16{8'(i*37+5)}};
         tbl[i].k  = i[0] ? KB : KA;
         tbl[i].ev = evp[i];
      end

      // asynchronous reset, then release mid-cycle with the pipeline stalled
      #1 round_rst_n = 1'b0;
      #1 chk_reset("reset");
      repeat (2) @(posedge round_clk);
      #3 round_rst_n = 1'b1;
      tick("rel_hold0", 1'b0, 1'b0, D, 128'h0, 1'b0);
      tick("rel_hold1", 1'b1, 1'b0, D, K28, 1'b0);

      // known-answer blocks, key changing every cycle, then an all-zero valid result
      tick("kat_a", 1'b1, 1'b1, D, 128'h0, 1'b0);
      tick("kat_b", 1'b1, 1'b1, D, K28, 1'b0);
      tick("kat_c", 1'b1, 1'b1, D, R27, 1'b1);
      chk("last_round_kat", out1, R27);
      tick("kat_d", 1'b0, 1'b1, KA, KB, 1'b1);
      chk("full_round_kat", out0, D);
      tick("kat_e", 1'b0, 1'b1, KB, KA, 1'b1);
      chk("zero_result0", out0, 128'h0);
      chk("zero_result1", out1, 128'h0);
      tick("kat_f", 1'b0, 1'b1, KA, KA, 1'b0);

      // stream, bubble pattern, and a 5-cycle stall with blocks in flight
      for (int i = 0; i < 24; i++)
         tick($sformatf("row%0d", i), tbl[i].v, tbl[i].en, tbl[i].d, tbl[i].k, tbl[i].ev);

      // reset between edges with two blocks in flight
      tick("pre_rst0", 1'b1, 1'b1, KA, KB, 1'b0);
      tick("pre_rst1", 1'b1, 1'b1, KB, KA, 1'b0);
      #3 round_rst_n = 1'b0;
      #1 chk_reset("mid_reset");
      hist_d.delete();
      hist_k.delete();
      exp0 = '0;
      exp1 = '0;
      @(posedge round_clk);
      #3 round_rst_n = 1'b1;
      tick("post_rst0", 1'b0, 1'b1, D, 128'h0, 1'b0);
      tick("post_rst1", 1'b0, 1'b1, D, 128'h0, 1'b0);
      tick("post_rst2", 1'b1, 1'b1, D, K28, 1'b0);
      tick("post_rst3", 1'b0, 1'b1, KA, KB, 1'b0);
      tick("post_rst4", 1'b0, 1'b1, KB, KA, 1'b1);
      chk("post_rst_block", out0, D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
